// File: rtl/sliding_window_3x3.sv
// sliding_window_3x3: 3x3 window producer over a raster pixel stream (optional SLIDING_WINDOW_SOF_EN adds a sof realignment input)
module sliding_window_3x3 #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] pix_in,
  input  logic          pix_valid,
`ifdef SLIDING_WINDOW_SOF_EN
  input  logic          sof,
`endif
  output logic [DW-1:0] sw_pixel_1,
  output logic [DW-1:0] sw_pixel_2,
  output logic [DW-1:0] sw_pixel_3,
  output logic [DW-1:0] sw_pixel_4,
  output logic [DW-1:0] sw_pixel_5,
  output logic [DW-1:0] sw_pixel_6,
  output logic [DW-1:0] sw_pixel_7,
  output logic [DW-1:0] sw_pixel_8,
  output logic [DW-1:0] sw_pixel_9,
  output logic          act,
  output logic          frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  logic [CW-1:0] col_q, col_e, col_d;
  logic [RW-1:0] row_q, row_e, row_d;
  logic [DW-1:0] lb1_q [IMG_W];
  logic [DW-1:0] lb2_q [IMG_W];
  logic [DW-1:0] tap_q [9];
  logic          sof_hit, last_col, last_row, act_q, fd_q;
`ifdef SLIDING_WINDOW_SOF_EN
  assign sof_hit = sof & pix_valid;
`else
  assign sof_hit = 1'b0;
`endif
  // effective position of the incoming pixel (sof forces 0,0) and the position after it
  always_comb begin
    col_e    = sof_hit ? '0 : col_q;
    row_e    = sof_hit ? '0 : row_q;
    last_col = col_e == CW'(IMG_W - 1);
    last_row = row_e == RW'(IMG_H - 1);
    col_d    = last_col ? '0 : col_e + 1'b1;
    row_d    = last_col ? (last_row ? '0 : row_e + 1'b1) : row_e;
  end
  // line buffers: lb1 keeps line r-1, lb2 keeps line r-2; contents need no reset
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb2_q[col_e] <= lb1_q[col_e];
      lb1_q[col_e] <= pix_in;
    end
  end
  // window shifts left one column per accepted pixel, new column enters on the right
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) tap_q[i] <= '0;
    end else if (pix_valid) begin
      tap_q[0] <= tap_q[1];
      tap_q[1] <= tap_q[2];
      tap_q[2] <= lb2_q[col_e];
      tap_q[3] <= tap_q[4];
      tap_q[4] <= tap_q[5];
      tap_q[5] <= lb1_q[col_e];
      tap_q[6] <= tap_q[7];
      tap_q[7] <= tap_q[8];
      tap_q[8] <= pix_in;
    end
  end
  // raster counters plus registered act / frame_done; border positions never raise act
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      act_q <= 1'b0;
      fd_q  <= 1'b0;
    end else begin
      act_q <= pix_valid && row_e >= RW'(2) && col_e >= CW'(2);
      fd_q  <= pix_valid && last_row && last_col;
      if (pix_valid) begin
        col_q <= col_d;
        row_q <= row_d;
      end
    end
  end
  assign sw_pixel_1 = tap_q[0];
  assign sw_pixel_2 = tap_q[1];
  assign sw_pixel_3 = tap_q[2];
  assign sw_pixel_4 = tap_q[3];
  assign sw_pixel_5 = tap_q[4];
  assign sw_pixel_6 = tap_q[5];
  assign sw_pixel_7 = tap_q[6];
  assign sw_pixel_8 = tap_q[7];
  assign sw_pixel_9 = tap_q[8];
  assign act        = act_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_sliding_window_3x3.sv
// tb_sliding_window_3x3: image-memory reference model of the 3x3 window producer, IMG_W=5 IMG_H=4
module tb_sliding_window_3x3;
  localparam int W = 5;
  localparam int H = 4;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] pix_in;
  logic pix_valid;
`ifdef SLIDING_WINDOW_SOF_EN
  logic sof;
`endif
  logic [7:0] s1, s2, s3, s4, s5, s6, s7, s8, s9;
  logic act, frame_done;
  logic [71:0] taps_w;
  int vectors = 0;
  int miscompares = 0;
  logic [71:0] win_q[$];
  bit fd_q[$];
  int fd_total = 0;
  int consec = 0;
  bit prev_act = 0;
  logic [7:0] img [H][W];
  int mr, mc;
  logic e_act, e_fd, e_known;
  logic [71:0] e_taps;

  always #5 clk = ~clk;

  sliding_window_3x3 #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
`ifdef SLIDING_WINDOW_SOF_EN
    .sof(sof),
`endif
    .sw_pixel_1(s1), .sw_pixel_2(s2), .sw_pixel_3(s3),
    .sw_pixel_4(s4), .sw_pixel_5(s5), .sw_pixel_6(s6),
    .sw_pixel_7(s7), .sw_pixel_8(s8), .sw_pixel_9(s9),
    .act(act), .frame_done(frame_done)
  );
  assign taps_w = {s1, s2, s3, s4, s5, s6, s7, s8, s9};

  // reference: record every accepted pixel at its raster position, read the window straight out of the image
  always @(posedge clk or posedge rst) begin
    logic [71:0] t;
    if (rst) begin
      mr = 0;
      mc = 0;
      e_act <= 1'b0;
      e_fd <= 1'b0;
      e_known <= 1'b1;
      e_taps <= '0;
    end else begin
      e_act <= 1'b0;
      e_fd <= 1'b0;
      if (pix_valid) begin
`ifdef SLIDING_WINDOW_SOF_EN
        if (sof) begin
          mr = 0;
          mc = 0;
        end
`endif
        img[mr][mc] = pix_in;
        if (mr >= 2 && mc >= 2) begin
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              t[(8 - (i * 3 + j)) * 8 +: 8] = img[mr - 2 + i][mc - 2 + j];
          e_taps <= t;
          e_act <= 1'b1;
          e_known <= 1'b1;
        end else begin
          e_known <= 1'b0;
        end
        e_fd <= (mr == H - 1 && mc == W - 1);
        mc = mc + 1;
        if (mc == W) begin
          mc = 0;
          mr = (mr == H - 1) ? 0 : mr + 1;
        end
      end
    end
  end

  task automatic chk(input string n, input logic [71:0] got, input logic [71:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic s);
    @(negedge clk);
    pix_valid = v;
    pix_in = d;
`ifdef SLIDING_WINDOW_SOF_EN
    sof = s;
`else
    if (s) $display("sof requested without SLIDING_WINDOW_SOF_EN");
`endif
  endtask

  task automatic frame(input logic [7:0] base, input bit tog, input int npix, input bit first_sof);
    for (int k = 0; k < npix; k++) begin
      cyc(1'b1, base + 8'((k / W) * 16 + (k % W)), first_sof && k == 0);
      if (tog) cyc(1'b0, 8'hEE, 1'b0);
    end
    cyc(1'b0, 8'h00, 1'b0);
  endtask

  localparam logic [71:0] FIRST_WIN = 72'h00_01_02_10_11_12_20_21_22;
  localparam logic [71:0] LAST_WIN  = 72'h12_13_14_22_23_24_32_33_34;

  initial begin
    int b, f, c;
    logic [71:0] w;
    rst = 1'b1;
    pix_valid = 1'b0;
    pix_in = '0;
`ifdef SLIDING_WINDOW_SOF_EN
    sof = 1'b0;
`endif
    fork
      forever begin
        @(posedge clk);
        #2;
        chk("act", {71'd0, act}, {71'd0, e_act});
        chk("frame_done", {71'd0, frame_done}, {71'd0, e_fd});
        if (e_known) chk("taps", taps_w, e_taps);
        if (act) begin
          win_q.push_back(taps_w);
          fd_q.push_back(frame_done);
          if (prev_act) consec++;
        end
        if (frame_done) fd_total++;
        prev_act = act;
      end
    join_none
    repeat (3) @(negedge clk);
    chk("reset_taps", taps_w, 72'd0);
    chk("reset_act", {71'd0, act}, 72'd0);
    rst = 1'b0;
    // continuous frame
    b = win_q.size(); f = fd_total;
    frame(8'h00, 1'b0, W * H, 1'b0);
    chk("cont_act_count", 72'(win_q.size() - b), 72'd6);
    if (win_q.size() >= b + 6) begin
      chk("cont_first_win", win_q[b], FIRST_WIN);
      chk("cont_last_win", win_q[b + 5], LAST_WIN);
      chk("cont_last_fd", {71'd0, fd_q[b + 5]}, 72'd1);
    end
    chk("cont_fd_count", 72'(fd_total - f), 72'd1);
    // valid toggling
    b = win_q.size(); c = consec;
    frame(8'h00, 1'b1, W * H, 1'b0);
    chk("tog_act_count", 72'(win_q.size() - b), 72'd6);
    chk("tog_no_consec", 72'(consec - c), 72'd0);
    if (win_q.size() >= b + 6) begin
      chk("tog_first_win", win_q[b], FIRST_WIN);
      chk("tog_last_win", win_q[b + 5], LAST_WIN);
    end
    // back-to-back frames
    b = win_q.size();
    for (int k = 0; k < W * H; k++) cyc(1'b1, 8'((k / W) * 16 + (k % W)), 1'b0);
    frame(8'h80, 1'b0, W * H, 1'b0);
    chk("b2b_act_count", 72'(win_q.size() - b), 72'd12);
    if (win_q.size() >= b + 7) begin
      w = win_q[b + 6];
      chk("b2b_tap1", 72'(w[71:64]), 72'h80);
      chk("b2b_tap9", 72'(w[7:0]), 72'hA2);
    end
    // reset mid-frame after pixel (2,3)
    b = win_q.size();
    frame(8'h00, 1'b0, 2 * W + 4, 1'b0);
    chk("pre_rst_acts", 72'(win_q.size() - b), 72'd2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_taps", taps_w, 72'd0);
    chk("midrst_act", {71'd0, act}, 72'd0);
    @(negedge clk);
    rst = 1'b0;
    b = win_q.size();
    frame(8'h00, 1'b0, W * H, 1'b0);
    chk("post_rst_count", 72'(win_q.size() - b), 72'd6);
    if (win_q.size() >= b + 6) chk("post_rst_first", win_q[b], FIRST_WIN);
    // random pixels and random valid gaps over two frames
    b = win_q.size(); f = fd_total;
    for (int k = 0; k < 2 * W * H; k++) begin
      while ($urandom_range(0, 3) == 0) cyc(1'b0, 8'($urandom), 1'b0);
      cyc(1'b1, 8'($urandom), 1'b0);
    end
    cyc(1'b0, 8'h00, 1'b0);
    chk("rand_act_count", 72'(win_q.size() - b), 72'd12);
    chk("rand_fd_count", 72'(fd_total - f), 72'd2);
`ifdef SLIDING_WINDOW_SOF_EN
    // abort a partial frame with sof
    b = win_q.size(); f = fd_total;
    frame(8'h00, 1'b0, 7, 1'b0);
    frame(8'h00, 1'b0, W * H, 1'b1);
    chk("sof_fd_count", 72'(fd_total - f), 72'd1);
    chk("sof_act_count", 72'(win_q.size() - b), 72'd6);
    if (win_q.size() >= b + 6) chk("sof_first_win", win_q[b], FIRST_WIN);
`endif
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
